// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-side bundle shared by the CPU, the loader and the arbiter.
// The master modport is the requester/memory side; the slave modport is the arbiter.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;
   logic              cpu_stall;

   logic              ldr_req;
   logic              ldr_we;
   logic [ADDR_W-1:0] ldr_addr;
   logic [DATA_W-1:0] ldr_wdata;
   logic [DATA_W-1:0] ldr_rdata;
   logic              ldr_ready;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              owner;
   logic              busy;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output ldr_req, ldr_we, ldr_addr, ldr_wdata,
      output mem_rdata,
      input  cpu_rdata, cpu_ready, cpu_stall,
      input  ldr_rdata, ldr_ready,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  owner, busy
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
      input  mem_rdata,
      output cpu_rdata, cpu_ready, cpu_stall,
      output ldr_rdata, ldr_ready,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output owner, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between CPU and loader; each access is
// IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE (one-cycle ready); requesters hold req until ready.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 2
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);

   localparam int CNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic              r_owner;
   logic              r_last_grant;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_ldr_rdata;

   logic              w_any_req;
   logic              w_grant_ldr;
   logic              w_last;
   logic              w_mem_en;
   logic              w_mem_we;
   logic              w_cpu_ready;
   logic              w_ldr_ready;
   logic              w_busy;

   assign w_any_req   = bus.cpu_req | bus.ldr_req;
   // Loader wins when alone, or on a tie when the CPU had the previous grant.
   assign w_grant_ldr = bus.ldr_req & (~bus.cpu_req | ~r_last_grant);
   assign w_last      = (r_cnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mem_en    = 1'b0;
      w_mem_we    = 1'b0;
      w_cpu_ready = 1'b0;
      w_ldr_ready = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            w_mem_en = 1'b1;
            w_mem_we = r_we;
            w_busy   = 1'b1;
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_busy      = 1'b1;
            w_cpu_ready = ~r_owner;
            w_ldr_ready = r_owner;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt        <= '0;
         r_we         <= 1'b0;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_cpu_rdata  <= '0;
         r_ldr_rdata  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_owner      <= w_grant_ldr;
                  r_last_grant <= w_grant_ldr;
                  r_we         <= w_grant_ldr ? bus.ldr_we    : bus.cpu_we;
                  r_addr       <= w_grant_ldr ? bus.ldr_addr  : bus.cpu_addr;
                  r_wdata      <= w_grant_ldr ? bus.ldr_wdata : bus.cpu_wdata;
                  r_cnt        <= CNT_W'(WAIT_STATES);
               end
            end
            S_ACCESS: begin
               if (w_last) begin
                  if (!r_we && r_owner) begin
                     r_ldr_rdata <= bus.mem_rdata;
                  end
                  if (!r_we && !r_owner) begin
                     r_cpu_rdata <= bus.mem_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.mem_en    = w_mem_en;
   assign bus.mem_we    = w_mem_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.ldr_rdata = r_ldr_rdata;
   assign bus.cpu_ready = w_cpu_ready;
   assign bus.ldr_ready = w_ldr_ready;
   assign bus.cpu_stall = bus.cpu_req & ~w_cpu_ready;
   assign bus.owner     = r_owner;
   assign bus.busy      = w_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus queues expected completions, per-DUT monitors check them on ready.
// A second instance is built with zero wait states.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int WS = 2;

   typedef struct packed {
      logic        owner;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] cpu_rd;
      logic [31:0] ldr_rd;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS)) u_dut0 (
      .clk (clk),
      .rst (rst_n),
      .bus (b0.slave)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(0)) u_dut1 (
      .clk (clk),
      .rst (rst_n),
      .bus (b1.slave)
   );

   int n_chk  = 0;
   int n_pass = 0;
   exp_t q0[$];
   exp_t q1[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
   endtask

   function automatic exp_t mk(input logic ow, input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] crd, input logic [31:0] lrd);
      mk = '{ow, we, a, wd, crd, lrd};
   endfunction

   // Memory model: data only valid in the last ACCESS cycle, junk before it.
   int acc_k0 = 0;
   int acc_k1 = 0;
   always @(posedge clk) begin
      acc_k0 <= b0.mem_en ? acc_k0 + 1 : 0;
      acc_k1 <= b1.mem_en ? acc_k1 + 1 : 0;
   end

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      mem_val = (a == 32'h40) ? 32'hDEADBEEF : (32'hC0DE0000 ^ a);
   endfunction

   assign b0.mem_rdata = (b0.mem_en && acc_k0 == WS) ? mem_val(b0.mem_addr) : 32'hA5A5A5A5;
   assign b1.mem_rdata = (b1.mem_en && acc_k1 == 0)  ? mem_val(b1.mem_addr) : 32'hA5A5A5A5;

   logic        in_acc0 = 1'b0;
   int          acc_n0  = 0;
   int          hold_err0 = 0;
   logic        cap_we0;
   logic [31:0] cap_addr0, cap_wd0;

   always @(negedge clk) begin : mon0
      exp_t e;
      if (!rst_n) begin
         in_acc0   = 1'b0;
         acc_n0    = 0;
         hold_err0 = 0;
      end else begin
         if (b0.mem_en) begin
            if (!in_acc0) begin
               in_acc0   = 1'b1;
               acc_n0    = 0;
               hold_err0 = 0;
               cap_we0   = b0.mem_we;
               cap_addr0 = b0.mem_addr;
               cap_wd0   = b0.mem_wdata;
               if (b0.cpu_req) chk("stall_in_access", 64'(b0.cpu_stall), 64'd1);
            end else if (b0.mem_we !== cap_we0 || b0.mem_addr !== cap_addr0 ||
                         b0.mem_wdata !== cap_wd0) begin
               hold_err0++;
            end
            acc_n0++;
         end
         if (b0.cpu_ready || b0.ldr_ready) begin
            chk("single_ready", 64'(b0.cpu_ready & b0.ldr_ready), 64'd0);
            chk("queue_nonempty_at_ready", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
               e = q0.pop_front();
               chk("ready_port", 64'(b0.ldr_ready), 64'(e.owner));
               chk("owner_out", 64'(b0.owner), 64'(e.owner));
               chk("mem_addr", 64'(cap_addr0), 64'(e.addr));
               chk("mem_we", 64'(cap_we0), 64'(e.we));
               if (e.we) chk("mem_wdata", 64'(cap_wd0), 64'(e.wdata));
               chk("access_cycles", 64'(acc_n0), 64'(WS + 1));
               chk("fields_held", 64'(hold_err0), 64'd0);
               chk("cpu_rdata", 64'(b0.cpu_rdata), 64'(e.cpu_rd));
               chk("ldr_rdata", 64'(b0.ldr_rdata), 64'(e.ldr_rd));
               chk("busy_in_done", 64'(b0.busy), 64'd1);
               if (b0.cpu_ready && b0.cpu_req) chk("stall_at_ready", 64'(b0.cpu_stall), 64'd0);
            end
            in_acc0 = 1'b0;
         end
      end
   end

   int          acc_n1 = 0;
   logic [31:0] cap_addr1;

   always @(negedge clk) begin : mon1
      exp_t e;
      if (!rst_n) begin
         acc_n1 = 0;
      end else begin
         if (b1.mem_en) begin
            if (acc_n1 == 0) cap_addr1 = b1.mem_addr;
            acc_n1++;
         end
         if (b1.cpu_ready || b1.ldr_ready) begin
            chk("ws0_queue_nonempty", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
               e = q1.pop_front();
               chk("ws0_ready_port", 64'(b1.ldr_ready), 64'(e.owner));
               chk("ws0_access_cycles", 64'(acc_n1), 64'd1);
               chk("ws0_mem_addr", 64'(cap_addr1), 64'(e.addr));
               chk("ws0_cpu_rdata", 64'(b1.cpu_rdata), 64'(e.cpu_rd));
            end
            acc_n1 = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges from now until the selected ready is seen, bounded.
   task automatic wait_ready(input int dut, input logic port, output int n);
      logic seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         tick();
         n++;
         if (dut == 0) seen = port ? b0.ldr_ready : b0.cpu_ready;
         else          seen = port ? b1.ldr_ready : b1.cpu_ready;
      end
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int n;
      int bad;
      rst_n = 1'b0;
      b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = 0; b0.cpu_wdata = 0;
      b0.ldr_req = 0; b0.ldr_we = 0; b0.ldr_addr = 0; b0.ldr_wdata = 0;
      b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
      b1.ldr_req = 0; b1.ldr_we = 0; b1.ldr_addr = 0; b1.ldr_wdata = 0;
      repeat (3) tick();

      chk("rst_mem_en",    64'(b0.mem_en),    64'd0);
      chk("rst_mem_we",    64'(b0.mem_we),    64'd0);
      chk("rst_mem_addr",  64'(b0.mem_addr),  64'd0);
      chk("rst_mem_wdata", 64'(b0.mem_wdata), 64'd0);
      chk("rst_cpu_rdata", 64'(b0.cpu_rdata), 64'd0);
      chk("rst_ldr_rdata", 64'(b0.ldr_rdata), 64'd0);
      chk("rst_readys",    64'({b0.cpu_ready, b0.ldr_ready}), 64'd0);
      chk("rst_busy",      64'(b0.busy),      64'd0);
      chk("rst_owner",     64'(b0.owner),     64'd0);

      rst_n = 1'b1;
      tick();

      // CPU read of 0x40.
      q0.push_back(mk(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 32'h0));
      b0.cpu_we = 0; b0.cpu_addr = 32'h40; b0.cpu_req = 1;
      wait_ready(0, 1'b0, n);
      chk("cpu_rd_latency", 64'(n), 64'(WS + 2));
      b0.cpu_req = 0;
      tick();

      // CPU read of 0x44 with the address changed to 0x88 mid-access.
      q0.push_back(mk(1'b0, 1'b0, 32'h44, 32'h0, 32'hC0DE0044, 32'h0));
      b0.cpu_addr = 32'h44; b0.cpu_req = 1;
      tick();
      b0.cpu_addr = 32'h88;
      #1;
      chk("field_chg_addr_kept", 64'(b0.mem_addr), 64'h44);
      wait_ready(0, 1'b0, n);
      chk("field_chg_latency", 64'(n), 64'(WS + 1));
      b0.cpu_req = 0;
      tick();
      chk("addr_hold_idle", 64'(b0.mem_addr), 64'h44);

      // Loader write.
      q0.push_back(mk(1'b1, 1'b1, 32'h100, 32'h12345678, 32'hC0DE0044, 32'h0));
      b0.ldr_we = 1; b0.ldr_addr = 32'h100; b0.ldr_wdata = 32'h12345678; b0.ldr_req = 1;
      wait_ready(0, 1'b1, n);
      chk("ldr_wr_latency", 64'(n), 64'(WS + 2));
      b0.ldr_req = 0;
      tick();
      chk("wdata_hold_idle", 64'(b0.mem_wdata), 64'h12345678);

      // Loader read leaves the CPU register alone.
      q0.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0, 32'hC0DE0044, 32'hC0DE0200));
      b0.ldr_we = 0; b0.ldr_addr = 32'h200; b0.ldr_wdata = 32'h0; b0.ldr_req = 1;
      wait_ready(0, 1'b1, n);
      chk("ldr_rd_latency", 64'(n), 64'(WS + 2));
      b0.ldr_req = 0;
      tick();

      // Contention from reset release: CPU, loader, CPU, loader.
      rst_n = 1'b0;
      tick();
      b0.cpu_we = 0; b0.cpu_addr = 32'h10; b0.cpu_req = 1;
      b0.ldr_we = 0; b0.ldr_addr = 32'h20; b0.ldr_req = 1;
      q0.push_back(mk(1'b0, 1'b0, 32'h10, 32'h0, 32'hC0DE0010, 32'h0));
      q0.push_back(mk(1'b1, 1'b0, 32'h20, 32'h0, 32'hC0DE0010, 32'hC0DE0020));
      q0.push_back(mk(1'b0, 1'b0, 32'h10, 32'h0, 32'hC0DE0010, 32'hC0DE0020));
      q0.push_back(mk(1'b1, 1'b0, 32'h20, 32'h0, 32'hC0DE0010, 32'hC0DE0020));
      rst_n = 1'b1;
      for (int g = 0; g < 4; g++) begin
         n   = 0;
         bad = 0;
         while (bad == 0 && n < 20) begin
            tick();
            n++;
            if (b0.cpu_ready || b0.ldr_ready) bad = 1;
         end
         chk("contention_period", 64'(n), (g == 0) ? 64'(WS + 2) : 64'(WS + 3));
         chk("contention_winner", 64'(b0.ldr_ready), 64'(g % 2));
      end
      b0.cpu_req = 0; b0.ldr_req = 0;
      repeat (2) tick();

      // Reset in the second ACCESS cycle aborts the read.
      b0.cpu_addr = 32'h40; b0.cpu_req = 1;
      tick();
      tick();
      chk("abort_pre_mem_en", 64'(b0.mem_en), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_mem_en",    64'(b0.mem_en),    64'd0);
      chk("abort_busy",      64'(b0.busy),      64'd0);
      chk("abort_cpu_rdata", 64'(b0.cpu_rdata), 64'd0);
      chk("abort_mem_addr",  64'(b0.mem_addr),  64'd0);
      b0.cpu_req = 0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (b0.cpu_ready || b0.ldr_ready) bad++;
         if (i == 3) rst_n = 1'b1;
      end
      chk("abort_no_ready", 64'(bad), 64'd0);
      chk("abort_idle_after", 64'(b0.busy), 64'd0);

      // Zero-wait-state instance.
      q1.push_back(mk(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 32'h0));
      b1.cpu_we = 0; b1.cpu_addr = 32'h40; b1.cpu_req = 1;
      wait_ready(1, 1'b0, n);
      chk("ws0_latency", 64'(n), 64'd2);
      b1.cpu_req = 0;
      repeat (3) tick();

      chk("q0_drained", 64'(q0.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between two requesters: the multicycle CPU (instruction/data port selected by IorD) and a program loader/debug port.
- Sequences every memory access through a fixed-latency handshake with a configurable wait-state count.
- Returns read data and a one-cycle ready pulse to the owning requester.
- Exports a stall signal that the CPU control FSM uses to hold its current state.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_STATES, 2, extra memory cycles per access (0 allowed); counter width is max(1, clog2(WAIT_STATES+1)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- cpu_req  in  1  CPU access request; held high until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  registered CPU read data.
- cpu_ready  out  1  one-cycle completion pulse to the CPU.
- cpu_stall  out  1  cpu_req & ~cpu_ready (combinational).
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_W/DATA_W  loader request fields; same semantics as the CPU fields.
- ldr_rdata  out  DATA_W  registered loader read data.
- ldr_ready  out  1  one-cycle completion pulse to the loader.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid in the final ACCESS cycle.
- owner  out  1  0 = CPU, 1 = loader; meaningful while busy.
- busy  out  1  high in the ACCESS and DONE states.

Behaviour:
- Reset (rst low, asynchronous) sets:
  - state IDLE;
  - mem_en = mem_we = 0; mem_addr, mem_wdata, cpu_rdata, ldr_rdata = 0;
  - cpu_ready = ldr_ready = 0; busy = 0; owner = 0;
  - last_grant = loader, so the CPU wins the first tie.
- States are IDLE, ACCESS and DONE.
- IDLE:
  - At a rising edge with any req high, grant and latch the granted requester's we/addr/wdata into mem_we/mem_addr/mem_wdata, set owner, load wait counter = WAIT_STATES, go to ACCESS.
  - With a single requester, that requester is granted.
  - With both requesting, the one not in last_grant is granted; last_grant is updated on every grant.
  - With no request, stay in IDLE.
- ACCESS:
  - mem_en = 1; mem_we = latched we.
  - Counter decrements each edge.
  - At the edge where the counter is 0: if read, capture mem_rdata into the owner's rdata register; go to DONE.
  - ACCESS lasts exactly WAIT_STATES+1 cycles.
- DONE:
  - mem_en = mem_we = 0; the owner's ready = 1 for exactly this cycle.
  - Next edge goes unconditionally to IDLE.
- Latency: with the request sampled at edge E0, ready is high from edge E0+WAIT_STATES+2 to E0+WAIT_STATES+3.
- Throughput: one access per WAIT_STATES+3 cycles.
- Request changes during ACCESS/DONE are ignored; the fields were latched at grant.
- A requester still holding req high in IDLE after its ready pulse is treated as a new access. With both requesting, this still alternates.
- Writes leave the rdata registers unchanged.
- The non-owner's rdata register is never modified.
- mem_addr and mem_wdata hold their last values in IDLE and DONE.
- Reset mid-ACCESS aborts the access: no ready pulse, no rdata update, outputs return to reset values.

Test Plan:
- (WAIT_STATES=2 throughout, except the last scenario.)
- CPU read: cpu_req=1, cpu_addr=0x40, mem_rdata=0xDEADBEEF in the final ACCESS cycle -> mem_en high for 3 cycles with mem_addr=0x40, mem_we=0; cpu_ready high 4 edges after sampling for 1 cycle; cpu_rdata=0xDEADBEEF; cpu_stall high until ready.
- Loader write: ldr_req=1, ldr_we=1, ldr_addr=0x100, ldr_wdata=0x12345678 -> mem_we=1 for 3 cycles with those values; ldr_ready pulses once; owner=1; cpu_rdata and ldr_rdata unchanged.
- Contention: both requests held high from reset release -> grants alternate CPU, loader, CPU, loader; each completes in 5 cycles; there are never two ready pulses in one cycle.
- Field change: change cpu_addr from 0x40 to 0x80 during ACCESS -> mem_addr stays 0x40 until DONE.
- Reset abort: rst low in the 2nd ACCESS cycle -> mem_en=0 and busy=0 immediately; no cpu_ready pulse; cpu_rdata=0.
- WAIT_STATES=0 build: CPU read -> ACCESS lasts 1 cycle; cpu_ready high 2 edges after sampling.
